// File: rtl/result_drain.sv
// Result drain: reads NUM_NEURONS accumulator words from the result BRAM,
// requantizes each to DATA_WIDTH with round-half-up and saturation, and
// streams them out over a valid/ready interface. Reads are credit-limited so
// the output FIFO can never overflow, whatever the back-pressure.
module result_drain #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_NEURONS  = 16,
  parameter int unsigned BRAM_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH   = BRAM_LATENCY + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(2*DATA_WIDTH)-1:0] shift_amt,
  output logic                            busy,
  output logic                            done,
  output logic                            sat_flag,
  output logic                            result_rd_en,
  output logic [ADDR_WIDTH-1:0]           result_rd_addr,
  input  logic [2*DATA_WIDTH-1:0]         result_rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_NEURONS)-1:0]  out_index,
  output logic                            out_last
);

  localparam int unsigned ShW   = $clog2(2 * DATA_WIDTH);
  localparam int unsigned IdxW  = $clog2(NUM_NEURONS);
  localparam int unsigned WordW = 2 * DATA_WIDTH;
  localparam int unsigned ExtW  = WordW + 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough for in-flight reads plus FIFO occupancy.
  localparam int unsigned CntW  = $clog2(BRAM_LATENCY + FIFO_DEPTH + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
  localparam logic signed [ExtW-1:0] MaxV = (ExtW'(1) <<< (DATA_WIDTH - 1)) - ExtW'(1);
  localparam logic signed [ExtW-1:0] MinV = ~MaxV;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e state_q, state_d;

  logic [ShW-1:0]          shift_q;
  logic [IdxW-1:0]         rd_idx_q;
  logic [IdxW-1:0]         cap_idx_q;
  logic [BRAM_LATENCY-1:0] pipe_q;
  logic                    sat_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [IdxW-1:0]       fifo_idx_q  [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [CntW-1:0] inflight, credit_used;
  logic            start_ok, capture, pop, sat_now;
  logic [DATA_WIDTH-1:0] rq_data;
  logic signed [ExtW-1:0] ext, round_add, rounded, shifted;

  assign start_ok = (state_q == StIdle) && start;
  assign capture  = pipe_q[BRAM_LATENCY-1];
  assign pop      = out_valid && out_ready;

  // Credits consumed: reads still in the BRAM pipe plus entries held in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CntW'(pipe_q[i]);
    end
    credit_used = inflight + count_q;
  end

  // Read issue and status outputs.
  always_comb begin
    result_rd_en   = (state_q == StRun) && (credit_used < CntW'(FIFO_DEPTH));
    result_rd_addr = ADDR_WIDTH'(rd_idx_q);
    busy           = (state_q != StIdle);
    done           = (state_q == StDone);
    sat_flag       = sat_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (result_rd_en && (rd_idx_q == LastIdx)) state_d = StFlush;
      StFlush: if (pop && out_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Requantize the word arriving from the BRAM this cycle.
  always_comb begin
    ext       = {result_rd_data[WordW-1], result_rd_data};
    round_add = '0;
    if (shift_q != '0) round_add = ExtW'(1) << (shift_q - ShW'(1));
    rounded = ext + round_add;
    shifted = rounded >>> shift_q;
    sat_now = 1'b0;
    rq_data = shifted[DATA_WIDTH-1:0];
    if (shifted > MaxV) begin
      rq_data = MaxV[DATA_WIDTH-1:0];
      sat_now = 1'b1;
    end else if (shifted < MinV) begin
      rq_data = MinV[DATA_WIDTH-1:0];
      sat_now = 1'b1;
    end
  end

  // Control state: FSM, shift latch, read/capture counters, in-flight pipe, sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      rd_idx_q  <= '0;
      cap_idx_q <= '0;
      pipe_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= (pipe_q << 1) | BRAM_LATENCY'(result_rd_en);
      if (start_ok) begin
        shift_q   <= shift_amt;
        rd_idx_q  <= '0;
        cap_idx_q <= '0;
        sat_q     <= 1'b0;
      end else begin
        if (result_rd_en && (rd_idx_q != LastIdx)) rd_idx_q <= rd_idx_q + IdxW'(1);
        if (capture) cap_idx_q <= cap_idx_q + IdxW'(1);
        if (capture && sat_now) sat_q <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(capture) - CntW'(pop);
    end
  end

  // FIFO storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (capture) begin
      fifo_data_q[wr_ptr_q] <= rq_data;
      fifo_idx_q[wr_ptr_q]  <= cap_idx_q;
      fifo_last_q[wr_ptr_q] <= (cap_idx_q == LastIdx);
    end
  end

  // Stream head, forced to zero when empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data  = fifo_data_q[rd_ptr_q];
      out_index = fifo_idx_q[rd_ptr_q];
      out_last  = fifo_last_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: BRAM model with 3-cycle read latency, stream monitor,
// and a behavioural requantization model computed with 64-bit arithmetic.
module tb_result_drain;

  localparam int NN    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = LAT + 2;

  logic        clk, rst, start, out_ready;
  logic [4:0]  shift_amt;
  logic        busy, done, sat_flag, result_rd_en, out_valid, out_last;
  logic [9:0]  result_rd_addr;
  logic [31:0] result_rd_data;
  logic [15:0] out_data;
  logic [3:0]  out_index;

  result_drain #(
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (16),
    .NUM_NEURONS (NN),
    .BRAM_LATENCY(LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .shift_amt     (shift_amt),
    .busy          (busy),
    .done          (done),
    .sat_flag      (sat_flag),
    .result_rd_en  (result_rd_en),
    .result_rd_addr(result_rd_addr),
    .result_rd_data(result_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model; non-read cycles load a marker so mistimed captures show up.
  logic [31:0] mem [NN];
  logic [31:0] st0, st1, st2;
  always @(posedge clk) begin
    st0 <= result_rd_en ? mem[result_rd_addr[3:0]] : 32'hDEAD_BEEF;
    st1 <= st0;
    st2 <= st1;
  end
  assign result_rd_data = st2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream and read-port monitor.
  logic [15:0] got_data[$];
  logic [3:0]  got_idx[$];
  logic        got_last[$];
  int          hs_cyc[$];
  int          done_cyc[$];
  logic [9:0]  rd_addrs[$];
  int          rd_pulses = 0, outst = 0, credit_viol = 0, stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] p_data;
  logic [3:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (prev_stall && (out_valid !== 1'b1 || out_data !== p_data || out_index !== p_idx ||
                       out_last !== p_last)) stall_err++;
    prev_stall = out_valid && !out_ready && !rst;
    p_data = out_data; p_idx = out_index; p_last = out_last;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_idx.push_back(out_index);
      got_last.push_back(out_last);
      hs_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (result_rd_en) begin
      rd_pulses++;
      rd_addrs.push_back(result_rd_addr);
    end
    if (rst) outst = 0;
    else outst = outst + int'(result_rd_en) - int'(out_valid && out_ready);
    if (outst > DEPTH) credit_viol++;
  end

  int n_cmp = 0, n_bad = 0;
  int base, dbase, rbase, abase, sbase, vbase, start_cyc;

  // Reference model: round half up, arithmetic shift, saturate to 16 bits.
  logic [15:0] exp_data [NN];
  bit          exp_sat;
  task automatic model_run(input int sh);
    longint v;
    exp_sat = 1'b0;
    for (int i = 0; i < NN; i++) begin
      v = longint'($signed(mem[i]));
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (v > 32767) begin v = 32767; exp_sat = 1'b1; end
      else if (v < -32768) begin v = -32768; exp_sat = 1'b1; end
      exp_data[i] = v[15:0];
    end
  endtask

  function automatic int ready_pattern(input int mode, input int k);
    if (mode == 1) return ($urandom_range(0, 3) != 0) ? 1 : 0;
    if (mode == 2) begin
      if (k >= 8 && k <= 27) return 0;
      if (k == 29 || k == 31) return 0;
    end
    return 1;
  endfunction

  // Runs one drain. mode 0: ready high, 1: random ready, 2: long stall then toggles,
  // 3: ready high with a start pulse and shift change mid-run.
  task automatic do_run(input logic [4:0] sh, input int mode);
    int k;
    base = got_data.size(); dbase = done_cyc.size(); rbase = rd_pulses;
    abase = rd_addrs.size(); sbase = stall_err; vbase = credit_viol;
    @(posedge clk); #1;
    shift_amt = sh; start = 1'b1; out_ready = 1'b1; start_cyc = cyc;
    k = 0;
    while (done_cyc.size() == dbase && k < 600) begin
      @(posedge clk); #1;
      k++;
      start = (mode == 3 && k == 4);
      if (mode == 3 && k == 2) shift_amt = sh ^ 5'h0A;
      if (mode == 3 && k == 4) shift_amt = sh ^ 5'h05;
      out_ready = ready_pattern(mode, k) != 0;
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int span);
    for (int i = 0; i < NN; i++)
      mem[i] = 32'($urandom_range(0, 2 * span - 1)) - 32'(span);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; out_ready = 1'b1; shift_amt = 5'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, sat_flag, result_rd_en, out_valid, out_last} !== 6'b0 ||
        out_data !== 16'h0 || out_index !== 4'h0 || result_rd_addr !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%b done=%b sat=%b rd_en=%b valid=%b last=%b data=%h idx=%h addr=%h want all 0",
               busy, done, sat_flag, result_rd_en, out_valid, out_last, out_data, out_index,
               result_rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_start_priority busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic;
    int n;
    for (int i = 0; i < NN; i++) mem[i] = 32'(i * 256);
    model_run(8);
    do_run(5'd8, 0);
    n = got_data.size() - base;
    n_cmp++;
    if (n !== NN) begin n_bad++; $display("FAIL basic_count got=%0d want=%0d", n, NN); end
    for (int i = 0; i < n && i < NN; i++) begin
      n_cmp++;
      if (got_data[base+i] !== 16'(i) || got_idx[base+i] !== 4'(i) ||
          got_last[base+i] !== (i == NN - 1) || hs_cyc[base+i] !== start_cyc + 5 + i) begin
        n_bad++;
        $display("FAIL basic_elem%0d got data=%0d idx=%0d last=%b cyc=%0d want data=%0d idx=%0d last=%b cyc=%0d",
                 i, got_data[base+i], got_idx[base+i], got_last[base+i],
                 hs_cyc[base+i] - start_cyc, i, i, (i == NN - 1), 5 + i);
      end
    end
    n_cmp++;
    if (done_cyc.size() - dbase !== 1) begin
      n_bad++; $display("FAIL basic_done_count got=%0d want=1", done_cyc.size() - dbase);
    end else if (n == NN) begin
      n_cmp++;
      if (done_cyc[dbase] !== hs_cyc[base+NN-1] + 1) begin
        n_bad++;
        $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc[dbase], hs_cyc[base+NN-1] + 1);
      end
    end
    n_cmp++;
    if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
    n_cmp++;
    if (rd_pulses - rbase !== NN) begin
      n_bad++; $display("FAIL basic_reads got=%0d want=%0d", rd_pulses - rbase, NN);
    end
    for (int i = 0; i < NN && abase + i < rd_addrs.size(); i++) begin
      n_cmp++;
      if (rd_addrs[abase+i] !== 10'(i)) begin
        n_bad++; $display("FAIL basic_addr%0d got=%0d want=%0d", i, rd_addrs[abase+i], i);
      end
    end
  endtask

  // Shared shape for the model-checked runs.
  task automatic test_model_run(input string name, input logic [4:0] sh, input int mode);
    int n;
    model_run(int'(sh));
    do_run(sh, mode);
    n = got_data.size() - base;
    n_cmp++;
    if (n !== NN) begin n_bad++; $display("FAIL %s_count got=%0d want=%0d", name, n, NN); end
    for (int i = 0; i < n && i < NN; i++) begin
      n_cmp++;
      if (got_data[base+i] !== exp_data[i] || got_idx[base+i] !== 4'(i) ||
          got_last[base+i] !== (i == NN - 1)) begin
        n_bad++;
        $display("FAIL %s_elem%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 name, i, got_data[base+i], got_idx[base+i], got_last[base+i], exp_data[i], i,
                 (i == NN - 1));
      end
    end
    n_cmp++;
    if (sat_flag !== exp_sat) begin
      n_bad++; $display("FAIL %s_sat got=%b want=%b", name, sat_flag, exp_sat);
    end
    n_cmp++;
    if (done_cyc.size() - dbase !== 1 || rd_pulses - rbase !== NN || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_run got dones=%0d reads=%0d busy=%b want 1 %0d 0", name,
               done_cyc.size() - dbase, rd_pulses - rbase, busy, NN);
    end
  endtask

  task automatic test_rounding;
    fill_random(1 << 23);
    mem[3] = 32'h0000_0180; mem[4] = 32'h0000_017F; mem[5] = -32'sh180;
    test_model_run("round", 5'd8, 1);
    n_cmp++;
    if (got_data.size() < base + 6 || got_data[base+3] !== 16'd2 || got_data[base+4] !== 16'd1 ||
        got_data[base+5] !== 16'hFFFF) begin
      n_bad++; $display("FAIL round_fixed got %h %h %h want 0002 0001 ffff",
                        got_data[base+3], got_data[base+4], got_data[base+5]);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < NN; i++) mem[i] = $urandom;
    mem[0] = 32'h0001_0000; mem[1] = 32'hFFFF_0000;
    test_model_run("sat", 5'd0, 0);
    n_cmp++;
    if (got_data.size() < base + 2 || got_data[base] !== 16'h7FFF ||
        got_data[base+1] !== 16'h8000 || sat_flag !== 1'b1) begin
      n_bad++; $display("FAIL sat_fixed got %h %h flag=%b want 7fff 8000 1",
                        got_data[base], got_data[base+1], sat_flag);
    end
  endtask

  task automatic test_stall;
    fill_random(1 << 20);
    test_model_run("stall", 5'($urandom_range(4, 12)), 2);
    n_cmp++;
    if (stall_err - sbase !== 0 || credit_viol - vbase !== 0) begin
      n_bad++; $display("FAIL stall_hold got stall_err=%0d credit_viol=%0d want 0 0",
                        stall_err - sbase, credit_viol - vbase);
    end
  endtask

  task automatic test_restart_ignored;
    fill_random(1 << 18);
    test_model_run("restart", 5'd6, 3);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      fill_random(1 << $urandom_range(10, 30));
      test_model_run("rand", 5'($urandom_range(0, 20)), 1);
    end
  endtask

  task automatic test_midrun_reset;
    int k, n0;
    fill_random(1 << 16);
    base = got_data.size();
    @(posedge clk); #1;
    shift_amt = 5'd5; start = 1'b1; out_ready = 1'b1;
    k = 0;
    while (got_data.size() - base < 8 && k < 100) begin
      @(posedge clk); #1;
      start = 1'b0; k++;
    end
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || got_idx[base+7] !== 4'd7) begin
      n_bad++; $display("FAIL midrst_stop got valid=%b busy=%b idx7=%0d want 0 0 7",
                        out_valid, busy, got_idx[base+7]);
    end
    n0 = got_data.size();
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (got_data.size() !== n0) begin
      n_bad++; $display("FAIL midrst_stale got=%0d want=0 elements", got_data.size() - n0);
    end
    fill_random(1 << 22);
    test_model_run("midrst", 5'd7, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; shift_amt = '0;
    for (int i = 0; i < NN; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturate();
    test_stall();
    test_restart_ignored();
    test_random();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: result BRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: output element width, where the result word is 2*DATA_WIDTH.
REQ-003 SHALL have parameter NUM_NEURONS, default 16: number of results drained per run.
REQ-004 SHALL have parameter BRAM_LATENCY, default 3: cycles from rd_en to valid rd_data.
REQ-005 SHALL have parameter FIFO_DEPTH, default BRAM_LATENCY+2: depth of the output buffer.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begins a drain run.
REQ-009 SHALL have port shift_amt, input, $clog2(2*DATA_WIDTH) bits: requantization right-shift.
REQ-010 SHALL have port busy, output, 1 bit: high while a run is active.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-012 SHALL have port sat_flag, output, 1 bit: sticky flag, set if any element saturated in the current run.
REQ-013 SHALL have port result_rd_en, output, 1 bit: result BRAM read enable.
REQ-014 SHALL have port result_rd_addr, output, ADDR_WIDTH bits: result BRAM read address.
REQ-015 SHALL have port result_rd_data, input, 2*DATA_WIDTH bits: signed read data.
REQ-016 SHALL have port out_valid, output, 1 bit: stream valid.
REQ-017 SHALL have port out_ready, input, 1 bit: stream ready.
REQ-018 SHALL have port out_data, output, DATA_WIDTH bits: signed requantized element.
REQ-019 SHALL have port out_index, output, $clog2(NUM_NEURONS) bits: neuron index of out_data.
REQ-020 SHALL have port out_last, output, 1 bit: high with the element at index NUM_NEURONS-1.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
- IDLE->RUN on start.
- RUN->FLUSH after the read of address NUM_NEURONS-1 is issued.
- FLUSH->DONE on the handshake of the last element.
- DONE->IDLE unconditionally after one cycle.
REQ-022 SHALL latch shift_amt on start; changes to shift_amt during a run have no effect.
REQ-023 SHALL ignore start when not in IDLE.
REQ-024 SHALL clear sat_flag on an accepted start.
REQ-025 SHALL drive busy high in RUN, FLUSH and DONE, and drive done high only in DONE.
REQ-026 SHALL issue reads to addresses 0..NUM_NEURONS-1 in ascending order, each exactly once per run, with result_rd_addr zero-extended.
REQ-027 SHALL assert result_rd_en in a cycle only when (reads in flight + FIFO occupancy) < FIFO_DEPTH; this is the credit rule.
REQ-028 SHALL track in-flight reads with a BRAM_LATENCY-deep valid shift register and capture result_rd_data when its tail is high.
REQ-029 SHALL requantize each captured value as follows:
- compute in 2*DATA_WIDTH+1 bits;
- if shift_amt > 0, add 2^(shift_amt-1) (round half up);
- arithmetic shift right by shift_amt;
- saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-030 SHALL set sat_flag in the cycle after any saturating element is captured.
REQ-031 SHALL write the requantized value, its index and its last flag into the FIFO one cycle after capture.
REQ-032 SHALL present the FIFO head on out_data, out_index and out_last, with out_valid = FIFO not empty.
REQ-033 SHALL complete a transfer on out_valid && out_ready, and pop the FIFO in that cycle.
REQ-034 SHALL hold out_data, out_index and out_last stable while out_valid && !out_ready.
REQ-035 SHALL never overflow the FIFO, with a simultaneous push and pop on a full FIFO leaving the occupancy unchanged.
REQ-036 SHALL, with out_ready held high, assert the first out_valid BRAM_LATENCY+2 cycles after the start cycle and sustain one element per cycle.
REQ-037 SHALL assert done in the cycle after the last handshake.
REQ-038 SHALL deliver exactly NUM_NEURONS elements per run, in index order.

Reset
REQ-039 SHALL, on rst, drive busy, done, sat_flag, result_rd_en, out_valid, out_data, out_index, out_last and result_rd_addr to 0 and return the FSM to IDLE.
REQ-040 SHALL, on rst, clear the FIFO and the in-flight valid pipe, with no stale BRAM data emitted afterwards.
REQ-041 SHALL give rst priority over start in the same cycle.
REQ-042 SHALL, when rst is applied mid-run, drive out_valid low from the next cycle, with a following start restarting at index 0.

Verification (DATA_WIDTH=16, NUM_NEURONS=16, BRAM_LATENCY=3)
REQ-043 SHALL cover: BRAM[i]=i*256, shift_amt=8, out_ready=1 -> out_data=i and out_index=i for i=0..15, first out_valid 5 cycles after start, out_last only at index 15, done 1 cycle after the last handshake, sat_flag=0.
REQ-044 SHALL cover: shift_amt=8 with values 0x180, 0x17F and -0x180 -> outputs 2, 1 and -1 respectively.
REQ-045 SHALL cover: shift_amt=0 with values 0x00010000 and 0xFFFF0000 -> outputs 32767 and -32768, and sat_flag=1.
REQ-046 SHALL cover: out_ready low for 20 cycles mid-run, then toggled 1,0,1,0 -> out_data stable while stalled, no element lost or duplicated, exactly 16 result_rd_en pulses, in-flight+occupancy never above FIFO_DEPTH.
REQ-047 SHALL cover: start pulsed during RUN with shift_amt changed -> run unaffected and the original shift is used.
REQ-048 SHALL cover: rst after index 7 has been delivered, then start -> out_valid low next cycle, then a fresh sequence starting at index 0.
